mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 176 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller sitting in front of the 4 KB data memory.
// One request per handshake; registered response with alignment-error flags.
module mem_access_unit #(
    parameter int ADDR_LSB = 2,
    parameter int ADDR_MSB = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [3:0]                 req_op,
    input  logic [31:0]                req_addr,
    input  logic [31:0]                req_wdata,
    input  logic [4:0]                 req_rd,
    output logic [ADDR_MSB-ADDR_LSB:0] dm_addr,
    output logic [3:0]                 dm_be,
    output logic [31:0]                dm_din,
    output logic                       dm_wr,
    input  logic [31:0]                dm_dout,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [31:0]                resp_rdata,
    output logic [4:0]                 resp_rd,
    output logic                       resp_is_load,
    output logic                       exc_adel,
    output logic                       exc_ades,
    output logic [31:0]                exc_badvaddr
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  rrd_q, rrd_d;
    logic        rload_q, rload_d;
    logic        adel_q, adel_d;
    logic        ades_q, ades_d;
    logic [31:0] bad_q, bad_d;

    logic is_lb, is_lh, is_lw, is_lbu, is_lhu, is_sb, is_sh, is_sw;
    logic byte_op, half_op, word_op, load_op, store_op, mis, accept;
    logic [3:0]  be_c;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_data;

    assign is_lb  = (op_q == 4'b0000);
    assign is_lh  = (op_q == 4'b0001);
    assign is_lw  = (op_q == 4'b0010);
    assign is_lbu = (op_q == 4'b0100);
    assign is_lhu = (op_q == 4'b0101);
    assign is_sb  = (op_q == 4'b1000);
    assign is_sh  = (op_q == 4'b1001);
    assign is_sw  = (op_q == 4'b1010);

    assign byte_op  = is_lb | is_lbu | is_sb;
    assign half_op  = is_lh | is_lhu | is_sh;
    assign word_op  = is_lw | is_sw;
    assign load_op  = is_lb | is_lh | is_lw | is_lbu | is_lhu;
    assign store_op = is_sb | is_sh | is_sw;
    assign mis      = (half_op && addr_q[0]) ||
                      (word_op && (addr_q[1:0] != 2'b00));

    always_comb begin
        be_c = 4'b0000;
        if (!mis) begin
            if (byte_op)      be_c = 4'b0001 << addr_q[1:0];
            else if (half_op) be_c = addr_q[1] ? 4'b1100 : 4'b0011;
            else if (word_op) be_c = 4'b1111;
        end
    end

    // Byte 0 of the memory word is dm_dout[7:0]
    assign byte_sel = dm_dout[{addr_q[1:0], 3'b000} +: 8];
    assign half_sel = addr_q[1] ? dm_dout[31:16] : dm_dout[15:0];

    always_comb begin
        ld_data = 32'h0;
        if (is_lb)  ld_data = {{24{byte_sel[7]}}, byte_sel};
        if (is_lbu) ld_data = {24'h0, byte_sel};
        if (is_lh)  ld_data = {{16{half_sel[15]}}, half_sel};
        if (is_lhu) ld_data = {16'h0, half_sel};
        if (is_lw)  ld_data = dm_dout;
    end

    assign req_ready = (state_q == IDLE) && (!rvalid_q || resp_ready) && !rst;
    assign accept    = req_valid && req_ready;

    assign dm_addr = addr_q[ADDR_MSB:ADDR_LSB];
    assign dm_din  = wdata_q;
    assign dm_be   = (state_q == ACCESS) ? be_c : 4'b0000;
    // Gated by rst so a reset during ACCESS suppresses the falling-edge write
    assign dm_wr   = (state_q == ACCESS) && store_op && !mis && !rst;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rrd_d    = rrd_q;
        rload_d  = rload_q;
        adel_d   = adel_q;
        ades_d   = ades_q;
        bad_d    = bad_q;
        if (rvalid_q && resp_ready) rvalid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rd_d    = req_rd;
                    state_d = ACCESS;
                end
            end
            default: begin
                state_d  = IDLE;
                rvalid_d = 1'b1;
                rdata_d  = (load_op && !mis) ? ld_data : 32'h0;
                rrd_d    = rd_q;
                rload_d  = load_op && !mis;
                adel_d   = load_op && mis;
                ades_d   = store_op && mis;
                bad_d    = mis ? addr_q : 32'h0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= 4'h0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rd_q     <= 5'h0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            rrd_q    <= 5'h0;
            rload_q  <= 1'b0;
            adel_q   <= 1'b0;
            ades_q   <= 1'b0;
            bad_q    <= 32'h0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rrd_q    <= rrd_d;
            rload_q  <= rload_d;
            adel_q   <= adel_d;
            ades_q   <= ades_d;
            bad_q    <= bad_d;
        end
    end

    assign resp_valid   = rvalid_q;
    assign resp_rdata   = rdata_q;
    assign resp_rd      = rrd_q;
    assign resp_is_load = rload_q;
    assign exc_adel     = adel_q;
    assign exc_ades     = ades_q;
    assign exc_badvaddr = bad_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-addressed reference memory model, a
// per-cycle response comparator and directed literal checks.
module tb_mem_access_unit;

    localparam logic [3:0] LB = 4'b0000, LH = 4'b0001, LW = 4'b0010;
    localparam logic [3:0] LBU = 4'b0100, LHU = 4'b0101;
    localparam logic [3:0] SB = 4'b1000, SH = 4'b1001, SW = 4'b1010;
    localparam logic [3:0] NOP = 4'b1111;

    typedef struct packed {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        is_load;
        logic        adel;
        logic        ades;
        logic [31:0] bad;
        logic [3:0]  be;
        logic        wr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic [9:0]  dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_din, dm_dout;
    logic        dm_wr;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_is_load, exc_adel, exc_ades;
    logic [31:0] exc_badvaddr;

    int nchk = 0;
    int nerr = 0;
    int wr_cnt = 0;

    logic [31:0] mem [1024];
    logic [7:0]  ref_b [4096];
    exp_t        expq [$];

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .dm_addr(dm_addr), .dm_be(dm_be), .dm_din(dm_din),
        .dm_wr(dm_wr), .dm_dout(dm_dout),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_rd(resp_rd),
        .resp_is_load(resp_is_load),
        .exc_adel(exc_adel), .exc_ades(exc_ades),
        .exc_badvaddr(exc_badvaddr)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h9E37_79B1 + 32'h0102_0304;
    endfunction

    // Environment memory: combinational read, falling-edge write
    assign dm_dout = mem[dm_addr];

    always @(negedge clk) begin
        if (dm_wr) begin
            wr_cnt++;
            case (dm_be)
                4'b1111: mem[dm_addr] = dm_din;
                4'b0011: mem[dm_addr][15:0] = dm_din[15:0];
                4'b1100: mem[dm_addr][31:16] = dm_din[15:0];
                4'b0001: mem[dm_addr][7:0] = dm_din[7:0];
                4'b0010: mem[dm_addr][15:8] = dm_din[7:0];
                4'b0100: mem[dm_addr][23:16] = dm_din[7:0];
                4'b1000: mem[dm_addr][31:24] = dm_din[7:0];
                default: ;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference behaviour over a byte-addressed 4 KB space
    task automatic model(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd,
                         output exp_t e);
        bit ld, st, sgn, mis;
        int sz, ba;
        longint v;
        ld  = op inside {LB, LH, LW, LBU, LHU};
        st  = op inside {SB, SH, SW};
        sgn = ld && (op[2] == 1'b0);
        sz  = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
        mis = (ld || st) && ((a % sz) != 0);
        ba  = int'(a[11:0]);
        e = '0;
        e.rd = rd;
        if ((ld || st) && !mis)
            e.be = 4'(((1 << sz) - 1) << (a % 4));
        e.wr = st && !mis;
        e.adel = ld && mis;
        e.ades = st && mis;
        e.bad = mis ? a : 32'h0;
        e.is_load = ld && !mis;
        if (ld && !mis) begin
            v = 0;
            for (int k = 0; k < sz; k++)
                v = v | (longint'(ref_b[ba + k]) << (8 * k));
            if (sgn && v[8 * sz - 1]) v = v | (-64'sd1 << (8 * sz));
            e.rdata = v[31:0];
        end
        if (st && !mis)
            for (int k = 0; k < sz; k++)
                ref_b[ba + k] = 8'(wd >> (8 * k));
    endtask

    // Drive at a negedge; returns at the negedge inside ACCESS
    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd,
                         output exp_t e);
        int n;
        req_valid = 1'b1;
        req_op = op;
        req_addr = a;
        req_wdata = wd;
        req_rd = rd;
        #1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept_timeout", 32'(req_ready), 32'd1);
        model(op, a, wd, rd, e);
        expq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("dm_be", 32'(dm_be), 32'(e.be));
        chk("dm_wr", 32'(dm_wr), 32'(e.wr));
        chk("dm_addr", 32'(dm_addr), 32'(a[11:2]));
        chk("dm_din", dm_din, wd);
        chk("req_ready_access", 32'(req_ready), 32'd0);
    endtask

    // Per-cycle response comparison against the model queue
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (expq.size() == 0) begin
                chk("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
                chk("resp_rdata", resp_rdata, expq[0].rdata);
                chk("resp_rd", 32'(resp_rd), 32'(expq[0].rd));
                chk("resp_is_load", 32'(resp_is_load), 32'(expq[0].is_load));
                chk("exc_adel", 32'(exc_adel), 32'(expq[0].adel));
                chk("exc_ades", 32'(exc_ades), 32'(expq[0].ades));
                chk("exc_badvaddr", exc_badvaddr, expq[0].bad);
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && resp_valid && resp_ready && expq.size() > 0)
            void'(expq.pop_front());
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int w0;
        logic [31:0] w;
        for (int i = 0; i < 1024; i++) begin
            w = init_word(i);
            mem[i] = w;
            for (int k = 0; k < 4; k++) ref_b[4 * i + k] = w[8 * k +: 8];
        end
        rst = 1'b1;
        req_valid = 1'b1;
        req_op = LW;
        req_addr = 32'h10;
        req_wdata = 32'h0;
        req_rd = 5'd0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_dm_wr", 32'(dm_wr), 32'd0);
        chk("rst_dm_be", 32'(dm_be), 32'd0);
        chk("rst_dm_addr", 32'(dm_addr), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_badvaddr", exc_badvaddr, 32'd0);
        rst = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);

        issue(SW, 32'h10, 32'hDEADBEEF, 5'd1, e);
        chk("sw_be_lit", 32'(e.be), 32'hF);
        issue(LW, 32'h10, 32'h0, 5'd2, e);
        @(negedge clk);
        chk("lw_rdata_lit", resp_rdata, 32'hDEADBEEF);
        chk("lw_is_load_lit", 32'(resp_is_load), 32'd1);
        #1 chk("sw_one_write", 32'(wr_cnt), 32'd1);

        issue(SB, 32'h13, 32'h80, 5'd3, e);
        chk("sb_be_lit", 32'(e.be), 32'b1000);
        issue(LB, 32'h13, 32'h0, 5'd4, e);
        @(negedge clk);
        chk("lb_lit", resp_rdata, 32'hFFFFFF80);
        issue(LBU, 32'h13, 32'h0, 5'd5, e);
        @(negedge clk);
        chk("lbu_lit", resp_rdata, 32'h00000080);

        issue(SH, 32'h22, 32'h8001, 5'd6, e);
        chk("sh_be_lit", 32'(e.be), 32'b1100);
        issue(LH, 32'h22, 32'h0, 5'd7, e);
        @(negedge clk);
        chk("lh_lit", resp_rdata, 32'hFFFF8001);
        issue(LHU, 32'h20, 32'h0, 5'd8, e);
        @(negedge clk);
        w = init_word(8);
        chk("lhu_old_low", resp_rdata, {16'h0, w[15:0]});

        #1 w0 = wr_cnt;
        issue(LW, 32'h05, 32'h0, 5'd9, e);
        @(negedge clk);
        chk("adel_lit", 32'(exc_adel), 32'd1);
        chk("adel_bad_lit", exc_badvaddr, 32'h05);
        chk("adel_rdata_lit", resp_rdata, 32'h0);
        issue(SH, 32'h07, 32'hFFFF, 5'd10, e);
        @(negedge clk);
        chk("ades_lit", 32'(exc_ades), 32'd1);
        chk("ades_bad_lit", exc_badvaddr, 32'h07);
        #1 chk("ades_no_write", 32'(wr_cnt), 32'(w0));
        chk("ades_mem_kept", mem[1], init_word(1));

        issue(LW, 32'h10, 32'h0, 5'd11, e);
        resp_ready = 1'b0;
        req_valid = 1'b1;
        req_op = NOP;
        req_addr = 32'h44;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_rdata_lit", resp_rdata, 32'h80ADBEEF);
        end
        resp_ready = 1'b1;
        #1 chk("stall_release", 32'(req_ready), 32'd1);
        issue(NOP, 32'h44, 32'h1234, 5'd12, e);
        chk("nop_be_lit", 32'(e.be), 32'd0);
        repeat (2) @(negedge clk);

        #1 w0 = wr_cnt;
        req_valid = 1'b1;
        req_op = SW;
        req_addr = 32'h40;
        req_wdata = 32'h12345678;
        req_rd = 5'd13;
        chk("rstacc_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstacc_dm_wr", 32'(dm_wr), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rstacc_resp_valid", 32'(resp_valid), 32'd0);
        #1 chk("rstacc_no_write", 32'(wr_cnt), 32'(w0));
        chk("rstacc_mem_kept", mem[16], init_word(16));
        rst = 1'b0;
        @(negedge clk);

        issue(LW, 32'h1010, 32'h0, 5'd14, e);
        @(negedge clk);
        chk("wrap_lit", resp_rdata, 32'h80ADBEEF);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(expq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
